// File: rtl/mio_bus_if.sv
// CPU-side memory/IO bus between the multi-cycle controller and mio_bus.
// The CPU owns the request side; mio_bus returns ready, load data and bus_err.
interface mio_bus_if;
  logic        MemRead;
  logic        MemWrite;
  logic        CPU_MIO;
  logic [31:0] addr_bus;
  logic [31:0] cpu_data_out;
  logic        MIO_ready;
  logic [31:0] cpu_data_in;
  logic        bus_err;

  modport master (
    output MemRead, MemWrite, CPU_MIO, addr_bus, cpu_data_out,
    input  MIO_ready, cpu_data_in, bus_err
  );

  modport slave (
    input  MemRead, MemWrite, CPU_MIO, addr_bus, cpu_data_out,
    output MIO_ready, cpu_data_in, bus_err
  );
endinterface

// File: rtl/mio_bus.sv
// Memory/IO bus slave: decodes CPU accesses to RAM, GPIO or the counter,
// inserts per-target wait states and returns a one-cycle MIO_ready strobe.
module mio_bus #(
  parameter int RAM_WAIT = 1,
  parameter int IO_WAIT  = 2,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_if.slave          bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  output logic [31:0]       gpio_out,
  input  logic [31:0]       sw_in,
  output logic              counter_we,
  output logic [31:0]       counter_wdata,
  input  logic [31:0]       counter_val
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {TGT_RAM, TGT_GPIO, TGT_CNT, TGT_NONE} target_t;

  localparam logic [7:0] RAM_W = 8'(RAM_WAIT);
  localparam logic [7:0] IO_W  = 8'(IO_WAIT);

  state_t      state;
  target_t     tgt_q;
  target_t     dec_tgt;
  target_t     acc_tgt;
  logic        wr_q;
  logic        acc_wr;
  logic [7:0]  cnt;
  logic [7:0]  dec_wait;
  logic [31:0] acc_data;
  logic        req;
  logic        enter_done;
  logic        unused_addr;

  assign req         = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
  assign unused_addr = ^{bus.addr_bus[27:RAM_AW+2], bus.addr_bus[1:0]};

  // In IDLE a zero-wait access completes straight from the live bus inputs;
  // otherwise completion works from the values latched at acceptance.
  always_comb begin
    dec_tgt  = TGT_NONE;
    dec_wait = 8'd0;
    case (bus.addr_bus[31:28])
      4'h0: begin dec_tgt = TGT_RAM;  dec_wait = RAM_W; end
      4'hE: begin dec_tgt = TGT_GPIO; dec_wait = IO_W;  end
      4'hF: begin dec_tgt = TGT_CNT;  dec_wait = IO_W;  end
      default: ;
    endcase

    if (state == IDLE) begin
      acc_tgt  = dec_tgt;
      acc_wr   = bus.MemWrite;
      acc_data = bus.cpu_data_out;
    end else begin
      acc_tgt  = tgt_q;
      acc_wr   = wr_q;
      acc_data = ram_din;
    end

    enter_done = req && (((state == IDLE) && (dec_wait == 8'd0)) ||
                         ((state == WAIT) && (cnt == 8'd0)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      tgt_q           <= TGT_NONE;
      wr_q            <= 1'b0;
      cnt             <= 8'd0;
      bus.MIO_ready   <= 1'b0;
      bus.bus_err     <= 1'b0;
      bus.cpu_data_in <= 32'h0;
      ram_addr        <= '0;
      ram_din         <= 32'h0;
      ram_we          <= 1'b0;
      gpio_out        <= 32'h0;
      counter_we      <= 1'b0;
      counter_wdata   <= 32'h0;
    end else begin
      bus.MIO_ready <= 1'b0;
      bus.bus_err   <= 1'b0;
      ram_we        <= 1'b0;
      counter_we    <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            tgt_q         <= dec_tgt;
            wr_q          <= bus.MemWrite;
            ram_addr      <= bus.addr_bus[RAM_AW+1:2];
            ram_din       <= bus.cpu_data_out;
            counter_wdata <= bus.cpu_data_out;
            if (dec_wait == 8'd0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= dec_wait - 8'd1;
            end
          end
        end
        WAIT: begin
          if (!req)
            state <= IDLE;
          else if (cnt == 8'd0)
            state <= DONE;
          else
            cnt <= cnt - 8'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Strobes are registered on DONE entry so they are high exactly in DONE.
      if (enter_done) begin
        bus.MIO_ready <= 1'b1;
        bus.bus_err   <= (acc_tgt == TGT_NONE);
        ram_we        <= acc_wr && (acc_tgt == TGT_RAM);
        counter_we    <= acc_wr && (acc_tgt == TGT_CNT);
        if (acc_wr) begin
          if (acc_tgt == TGT_GPIO)
            gpio_out <= acc_data;
        end else begin
          case (acc_tgt)
            TGT_RAM:  bus.cpu_data_in <= ram_dout;
            TGT_GPIO: bus.cpu_data_in <= sw_in;
            TGT_CNT:  bus.cpu_data_in <= counter_val;
            default:  bus.cpu_data_in <= 32'h0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mio_bus.sv
// Randomized bench for mio_bus: a transaction-level scoreboard predicts
// latency, strobes, GPIO and load data from the address map and wait counts.
module tb_mio_bus;

  localparam int RAM_WAIT = 1;
  localparam int IO_WAIT  = 2;
  localparam int RAM_AW   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;
  logic [31:0]       gpio_out;
  logic [31:0]       sw_in;
  logic              counter_we;
  logic [31:0]       counter_wdata;
  logic [31:0]       counter_val;

  mio_bus_if bus ();

  mio_bus #(.RAM_WAIT(RAM_WAIT), .IO_WAIT(IO_WAIT), .RAM_AW(RAM_AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_we        (ram_we),
    .ram_dout      (ram_dout),
    .gpio_out      (gpio_out),
    .sw_in         (sw_in),
    .counter_we    (counter_we),
    .counter_wdata (counter_wdata),
    .counter_val   (counter_val)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_pattern(input int idx);
    return (32'(idx) * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Block RAM clocked on the falling edge, so data is ready for the next rising edge.
  bit [31:0] ram_array [1<<RAM_AW];
  bit        ram_valid [1<<RAM_AW];
  always @(negedge clk) begin
    if (ram_we) begin
      ram_array[ram_addr] <= ram_din;
      ram_valid[ram_addr] <= 1'b1;
    end
    ram_dout <= ram_valid[ram_addr] ? ram_array[ram_addr] : init_pattern(int'(ram_addr));
  end

  int          assert_count;
  int          fail_count;
  logic [31:0] ref_gpio;
  logic [31:0] ref_data_in;
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] mem_ref(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_pattern(idx);
  endfunction

  // Targets: 0 RAM, 1 GPIO, 2 counter, 3 unmapped.
  function automatic int target_of(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'hE:    return 1;
      4'hF:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int wait_of(input int tgt);
    return (tgt == 0) ? RAM_WAIT : (tgt == 3) ? 0 : IO_WAIT;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, 32'({bus.MIO_ready, bus.bus_err, ram_we, counter_we}), 32'd0);
  endtask

  task automatic set_idle();
    bus.CPU_MIO  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // Called just after a falling edge with the slave idle; returns the same way.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input bit rd, input bit wr, input int abort_at);
    int tgt;
    int w;
    int idx;
    tgt = target_of(a);
    w   = wait_of(tgt);
    idx = int'(a[RAM_AW+1:2]);
    bus.CPU_MIO      = 1'b1;
    bus.MemRead      = rd;
    bus.MemWrite     = wr;
    bus.addr_bus     = a;
    bus.cpu_data_out = d;
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      if (k == 0 && tgt == 0)
        checkOutput("ram_addr", 32'(ram_addr), 32'(idx));
      if (k < w) begin
        checkQuiet("wait_quiet");
        if (k == abort_at) begin
          set_idle();
          repeat (3) begin
            @(negedge clk);
            checkQuiet("abort_quiet");
          end
          return;
        end
        bus.addr_bus     = $urandom;
        bus.cpu_data_out = $urandom;
      end else begin
        checkOutput("ready", 32'(bus.MIO_ready), 32'd1);
        checkOutput("bus_err", 32'(bus.bus_err), (tgt == 3) ? 32'd1 : 32'd0);
        checkOutput("ram_we", 32'(ram_we), (wr && tgt == 0) ? 32'd1 : 32'd0);
        checkOutput("counter_we", 32'(counter_we), (wr && tgt == 2) ? 32'd1 : 32'd0);
        if (wr) begin
          case (tgt)
            0: begin
              checkOutput("ram_din", ram_din, d);
              ref_mem[idx] = d;
            end
            1: ref_gpio = d;
            2: checkOutput("counter_wdata", counter_wdata, d);
            default: ;
          endcase
        end else begin
          case (tgt)
            0:       ref_data_in = mem_ref(idx);
            1:       ref_data_in = sw_in;
            2:       ref_data_in = counter_val;
            default: ref_data_in = 32'h0;
          endcase
        end
        checkOutput("gpio_out", gpio_out, ref_gpio);
        checkOutput("cpu_data_in", bus.cpu_data_in, ref_data_in);
      end
    end
    set_idle();
    @(negedge clk);
    checkQuiet("post_done");
    checkOutput("gpio_hold", gpio_out, ref_gpio);
    checkOutput("data_in_hold", bus.cpu_data_in, ref_data_in);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          t;
    int          op;
    int          ab;
    logic [31:0] a;
    assert_count = 0;
    fail_count   = 0;
    ref_gpio     = 32'h0;
    ref_data_in  = 32'h0;
    sw_in        = 32'h0;
    counter_val  = 32'h0;
    reset        = 1'b0;

    // Request held during reset must not be served.
    bus.CPU_MIO      = 1'b1;
    bus.MemRead      = 1'b1;
    bus.MemWrite     = 1'b0;
    bus.addr_bus     = 32'h0000_0010;
    bus.cpu_data_out = 32'h0;
    repeat (3) begin
      @(negedge clk);
      checkQuiet("reset_quiet");
    end
    checkOutput("reset_data_in", bus.cpu_data_in, 32'h0);
    checkOutput("reset_gpio", gpio_out, 32'h0);
    checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("reset_ram_din", ram_din, 32'h0);
    checkOutput("reset_cnt_wdata", counter_wdata, 32'h0);
    reset = 1'b1;
    applyStimulus(32'h0000_0010, 32'h0, 1'b1, 1'b0, -1);

    applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, -1);
    applyStimulus(32'h0000_0010, 32'h0, 1'b1, 1'b0, -1);
    applyStimulus(32'hE000_0000, 32'h0000_00A5, 1'b0, 1'b1, -1);
    applyStimulus(32'hF000_0004, 32'h0000_0100, 1'b0, 1'b1, -1);
    counter_val = 32'h55;
    applyStimulus(32'hF000_0004, 32'h0, 1'b1, 1'b0, -1);
    applyStimulus(32'h4000_0000, 32'h1357_9BDF, 1'b1, 1'b1, -1);

    // Aborted writes leave RAM and GPIO untouched.
    applyStimulus(32'hE000_0000, 32'h0000_005A, 1'b0, 1'b1, 1);
    applyStimulus(32'h0000_0020, 32'hCAFE_F00D, 1'b0, 1'b1, 0);
    applyStimulus(32'h0000_0020, 32'h0, 1'b1, 1'b0, -1);

    bus.CPU_MIO  = 1'b0;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkQuiet("no_cpu_mio");
    end
    set_idle();
    @(negedge clk);

    // Held RAM read: one ready every RAM_WAIT+2 cycles.
    bus.CPU_MIO  = 1'b1;
    bus.MemRead  = 1'b1;
    bus.addr_bus = 32'h0000_0010;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checkOutput("b2b_ready", 32'(bus.MIO_ready),
                  (k >= RAM_WAIT && (k - RAM_WAIT) % (RAM_WAIT + 2) == 0) ? 32'd1 : 32'd0);
    end
    set_idle();
    ref_data_in = mem_ref(4);
    repeat (2) @(negedge clk);
    checkOutput("b2b_data_in", bus.cpu_data_in, ref_data_in);

    // Reset during a counter write's wait abandons it.
    bus.CPU_MIO      = 1'b1;
    bus.MemWrite     = 1'b1;
    bus.addr_bus     = 32'hF000_0000;
    bus.cpu_data_out = 32'h0000_0077;
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    #1;
    checkQuiet("rst_abort_quiet");
    checkOutput("rst_abort_wdata", counter_wdata, 32'h0);
    @(negedge clk);
    reset       = 1'b1;
    ref_gpio    = 32'h0;
    ref_data_in = 32'h0;
    @(negedge clk);
    checkQuiet("rst_release_quiet");
    checkOutput("rst_gpio", gpio_out, 32'h0);

    for (int n = 0; n < 80; n++) begin
      t  = $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      case (t)
        0:       a = {4'h0, 16'($urandom), 6'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
        1:       a = {4'hE, 28'($urandom)};
        2:       a = {4'hF, 28'($urandom)};
        default: a = {4'($urandom_range(1, 13)), 28'($urandom)};
      endcase
      sw_in       = $urandom;
      counter_val = $urandom;
      ab = -1;
      if (wait_of(t) > 0 && $urandom_range(0, 7) == 0)
        ab = $urandom_range(0, wait_of(t) - 1);
      applyStimulus(a, $urandom, op != 1, op != 0, ab);
      if ($urandom_range(0, 3) == 0)
        @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
